mmss_bcd_counter: RTL and testbench

- Timekeeping core of the VGA timer. Holds an mm:ss value as four BCD digits and counts it up or down once per second from the 50 MHz clock.
- Digits feed the VGA painter stage. `finish` feeds the timer state machine.
- Accepts single-cycle set pulses for seconds and minutes from the state machine while paused.

---
 rtl/mmss_bcd_counter_if.sv | 24 ++
 rtl/mmss_bcd_counter.sv | 176 +++++++++++++++++
 tb/tb_mmss_bcd_counter.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mmss_bcd_counter_if.sv
// Control and BCD-digit bundle between the timer state machine, the mm:ss
// counter and the VGA painter stage.
interface mmss_bcd_counter_if;
    logic       enable;
    logic       forward;
    logic       inc_seconds;
    logic       inc_minutes;
    logic [3:0] sec_unit;
    logic [3:0] sec_dec;
    logic [3:0] min_unit;
    logic [3:0] min_dec;
    logic       tick;
    logic       finish;

    modport master (
        output enable, forward, inc_seconds, inc_minutes,
        input  sec_unit, sec_dec, min_unit, min_dec, tick, finish
    );

    modport slave (
        input  enable, forward, inc_seconds, inc_minutes,
        output sec_unit, sec_dec, min_unit, min_dec, tick, finish
    );
endinterface

// File: rtl/mmss_bcd_counter.sv
// mm:ss BCD up/down counter ticking once per TICK_DIV clocks, with set pulses
// while paused. Optional macro MMSS_UP_LIMIT_EN makes count-up saturate at 59:59.
module mmss_bcd_counter #(
    parameter int unsigned TICK_DIV = 50000000,
    parameter int unsigned PRESC_W  = 26
) (
    input  logic              clk,
    input  logic              reset,
    mmss_bcd_counter_if.slave bus
);

    localparam logic [PRESC_W-1:0] TICK_LAST_C = PRESC_W'(TICK_DIV - 1);

    // Each pair is {tens, units}; tens never exceeds 5.
    logic [7:0]         sec_r;
    logic [7:0]         min_r;
    logic               fin_r;
    logic               tick_r;
    logic [PRESC_W-1:0] presc_r;

    logic [7:0]         sec_nx_s;
    logic [7:0]         min_nx_s;
    logic               fin_nx_s;
    logic [PRESC_W-1:0] presc_nx_s;
    logic               tick_ev_s;
    logic               set_ev_s;
    logic               at_zero_s;
    logic               at_one_s;
    logic               at_max_s;

    // Top of a 00..59 BCD pair; out-of-range codes also count as top so they wrap to 00.
    function automatic logic bcd_is_max(input logic [7:0] v);
        logic r;
        if ((v[7:4] >= 4'd5) && (v[3:0] >= 4'd9)) begin
            r = 1'b1;
        end else begin
            r = 1'b0;
        end
        return r;
    endfunction

    // Increment a 00..59 BCD pair with wrap to 00.
    function automatic logic [7:0] bcd_inc60(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] >= 4'd9) begin
            if (v[7:4] >= 4'd5) begin
                r = 8'h00;
            end else begin
                r = {v[7:4] + 4'd1, 4'd0};
            end
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // Decrement a 00..59 BCD pair with wrap to 59.
    function automatic logic [7:0] bcd_dec60(input logic [7:0] v);
        logic [7:0] r;
        if ((v[3:0] == 4'd0) || (v[3:0] > 4'd9)) begin
            if ((v[7:4] == 4'd0) || (v[7:4] > 4'd5)) begin
                r = 8'h59;
            end else begin
                r = {v[7:4] - 4'd1, 4'd9};
            end
        end else begin
            r = {v[7:4], v[3:0] - 4'd1};
        end
        return r;
    endfunction

    // Tick event and set-pulse qualification from the current state.
    always_comb begin
        tick_ev_s = bus.enable && (presc_r == TICK_LAST_C);
        set_ev_s  = !bus.enable && (bus.inc_seconds || bus.inc_minutes);
        at_zero_s = (sec_r == 8'h00) && (min_r == 8'h00);
        at_one_s  = (sec_r == 8'h01) && (min_r == 8'h00);
        at_max_s  = bcd_is_max(sec_r) && bcd_is_max(min_r);
    end

    // Prescaler next value; a pause keeps the partial second.
    always_comb begin
        presc_nx_s = presc_r;
        if (bus.enable) begin
            if (presc_r == TICK_LAST_C) begin
                presc_nx_s = '0;
            end else begin
                presc_nx_s = presc_r + PRESC_W'(1);
            end
        end else begin
            presc_nx_s = presc_r;
        end
    end

    // Digit and finish next values: tick counting, or set pulses while paused.
    always_comb begin
        sec_nx_s = sec_r;
        min_nx_s = min_r;
        fin_nx_s = fin_r;
        if (tick_ev_s) begin
            if (bus.forward) begin
                if (at_max_s) begin
`ifdef MMSS_UP_LIMIT_EN
                    fin_nx_s = 1'b1;
`else
                    sec_nx_s = 8'h00;
                    min_nx_s = 8'h00;
`endif
                end else begin
                    sec_nx_s = bcd_inc60(sec_r);
                    if (bcd_is_max(sec_r)) begin
                        min_nx_s = bcd_inc60(min_r);
                    end else begin
                        min_nx_s = min_r;
                    end
                end
            end else begin
                if (at_zero_s) begin
                    fin_nx_s = 1'b1;
                end else begin
                    sec_nx_s = bcd_dec60(sec_r);
                    if (sec_r == 8'h00) begin
                        min_nx_s = bcd_dec60(min_r);
                    end else begin
                        min_nx_s = min_r;
                    end
                    // Landing on 00:00 raises finish on the same edge.
                    if (at_one_s) begin
                        fin_nx_s = 1'b1;
                    end else begin
                        fin_nx_s = fin_r;
                    end
                end
            end
        end else if (set_ev_s) begin
            if (bus.inc_seconds) begin
                sec_nx_s = bcd_inc60(sec_r);
            end else begin
                sec_nx_s = sec_r;
            end
            if (bus.inc_minutes) begin
                min_nx_s = bcd_inc60(min_r);
            end else begin
                min_nx_s = min_r;
            end
            fin_nx_s = 1'b0;
        end else begin
            fin_nx_s = fin_r;
        end
    end

    // State registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r <= '0;
            sec_r   <= 8'h00;
            min_r   <= 8'h00;
            fin_r   <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            presc_r <= presc_nx_s;
            sec_r   <= sec_nx_s;
            min_r   <= min_nx_s;
            fin_r   <= fin_nx_s;
            tick_r  <= tick_ev_s;
        end
    end

    assign bus.sec_unit = sec_r[3:0];
    assign bus.sec_dec  = sec_r[7:4];
    assign bus.min_unit = min_r[3:0];
    assign bus.min_dec  = min_r[7:4];
    assign bus.tick     = tick_r;
    assign bus.finish   = fin_r;

endmodule

// File: tb/tb_mmss_bcd_counter.sv
// Self-checking bench for mmss_bcd_counter: directed table, corner sequences
// and randomized traffic against a seconds-based reference model.
module tb_mmss_bcd_counter;

    localparam int TICK_DIV = 4;
`ifdef MMSS_UP_LIMIT_EN
    localparam bit UP_LIMIT = 1'b1;
`else
    localparam bit UP_LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    mmss_bcd_counter_if bus ();

    mmss_bcd_counter #(.TICK_DIV(TICK_DIV), .PRESC_W(26)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: total seconds, prescaler phase, tick and finish.
    int m_t     = 0;
    int m_presc = 0;
    bit m_tick  = 1'b0;
    bit m_fin   = 1'b0;

    typedef struct {
        logic r, en, fw, is, im;
        int   mm, ss;
        logic tk, fin;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(input logic r, en, fw, is, im,
                                input int mm, ss, input logic tk, fin);
        vec_t v;
        v.r = r; v.en = en; v.fw = fw; v.is = is; v.im = im;
        v.mm = mm; v.ss = ss; v.tk = tk; v.fin = fin;
        return v;
    endfunction

    task automatic step(input logic r, en, fw, is, im);
        bit ev;
        int mm, ss;
        reset = r; bus.enable = en; bus.forward = fw;
        bus.inc_seconds = is; bus.inc_minutes = im;
        if (r) begin
            m_t = 0; m_presc = 0; m_tick = 1'b0; m_fin = 1'b0;
        end else begin
            ev = en && (m_presc == TICK_DIV - 1);
            m_tick = ev;
            if (en) m_presc = (m_presc + 1) % TICK_DIV;
            if (ev) begin
                if (fw) begin
                    if (m_t == 3599) begin
                        if (UP_LIMIT) m_fin = 1'b1;
                        else m_t = 0;
                    end else begin
                        m_t = m_t + 1;
                    end
                end else if (m_t <= 1) begin
                    m_t = 0;
                    m_fin = 1'b1;
                end else begin
                    m_t = m_t - 1;
                end
            end else if (!en && (is || im)) begin
                mm = m_t / 60; ss = m_t % 60;
                if (is) ss = (ss + 1) % 60;
                if (im) mm = (mm + 1) % 60;
                m_t = mm * 60 + ss;
                m_fin = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int mm, ss, input logic tk, fin);
        n_tests++;
        if (bus.min_dec !== 4'(mm / 10) || bus.min_unit !== 4'(mm % 10) ||
            bus.sec_dec !== 4'(ss / 10) || bus.sec_unit !== 4'(ss % 10) ||
            bus.tick !== tk || bus.finish !== fin) begin
            n_fail++;
            $display("FAIL %s: got %0d%0d:%0d%0d tick=%0b finish=%0b, expected %02d:%02d tick=%0b finish=%0b",
                     name, bus.min_dec, bus.min_unit, bus.sec_dec, bus.sec_unit,
                     bus.tick, bus.finish, mm, ss, tk, fin);
        end
    endtask

    initial begin
        reset = 1'b1; bus.enable = 1'b0; bus.forward = 1'b1;
        bus.inc_seconds = 1'b0; bus.inc_minutes = 1'b0;

        // Directed table: set pulses, ignored pulses, pause, down to 00:00.
        tv.push_back(mk(1,0,0,0,0,  0, 0,0,0));
        tv.push_back(mk(0,0,0,1,0,  0, 1,0,0));
        tv.push_back(mk(0,0,0,1,0,  0, 2,0,0));
        tv.push_back(mk(0,0,0,1,0,  0, 3,0,0));
        tv.push_back(mk(0,0,0,0,1,  1, 3,0,0));
        tv.push_back(mk(0,0,0,0,1,  2, 3,0,0));
        tv.push_back(mk(0,0,0,1,1,  3, 4,0,0));
        tv.push_back(mk(0,1,1,1,0,  3, 4,0,0));
        tv.push_back(mk(0,1,1,0,1,  3, 4,0,0));
        tv.push_back(mk(0,1,1,0,0,  3, 4,0,0));
        tv.push_back(mk(0,1,1,0,0,  3, 5,1,0));
        tv.push_back(mk(0,1,0,0,0,  3, 5,0,0));
        tv.push_back(mk(0,1,0,0,0,  3, 5,0,0));
        tv.push_back(mk(0,0,0,0,0,  3, 5,0,0));
        tv.push_back(mk(0,1,0,0,0,  3, 5,0,0));
        tv.push_back(mk(0,1,0,0,0,  3, 4,1,0));
        tv.push_back(mk(1,1,0,0,0,  0, 0,0,0));
        tv.push_back(mk(0,0,0,1,0,  0, 1,0,0));
        tv.push_back(mk(0,0,0,1,0,  0, 2,0,0));
        for (int i = 0; i < 3; i++) tv.push_back(mk(0,1,0,0,0, 0, 2,0,0));
        tv.push_back(mk(0,1,0,0,0,  0, 1,1,0));
        for (int i = 0; i < 3; i++) tv.push_back(mk(0,1,0,0,0, 0, 1,0,0));
        tv.push_back(mk(0,1,0,0,0,  0, 0,1,1));
        for (int i = 0; i < 3; i++) tv.push_back(mk(0,1,0,0,0, 0, 0,0,1));
        tv.push_back(mk(0,1,0,0,0,  0, 0,1,1));
        tv.push_back(mk(0,0,0,1,0,  0, 1,0,0));

        for (int i = 0; i < tv.size(); i++) begin
            step(tv[i].r, tv[i].en, tv[i].fw, tv[i].is, tv[i].im);
            chk($sformatf("table[%0d]", i), tv[i].mm, tv[i].ss, tv[i].tk, tv[i].fin);
        end

        // 01:00 counting down borrows through both seconds digits.
        step(1,0,0,0,0);
        step(0,0,0,0,1);
        for (int i = 0; i < 3; i++) step(0,1,0,0,0);
        chk("pre_borrow", 1, 0, 1'b0, 1'b0);
        step(0,1,0,0,0);
        chk("borrow_0059", 0, 59, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(0,1,0,0,0);
        chk("borrow_0058", 0, 58, 1'b1, 1'b0);

        // 09:59 up carries into the minutes tens digit.
        step(1,0,0,0,0);
        for (int i = 0; i < 9; i++)  step(0,0,1,0,1);
        for (int i = 0; i < 59; i++) step(0,0,1,1,0);
        chk("load_0959", 9, 59, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(0,1,1,0,0);
        chk("carry_1000", 10, 0, 1'b1, 1'b0);

        // 59:59 up: wrap, or saturate with finish when the limit is built in.
        step(1,0,0,0,0);
        for (int i = 0; i < 59; i++) step(0,0,1,1,1);
        chk("load_5959", 59, 59, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(0,1,1,0,0);
        if (UP_LIMIT) chk("top_sat", 59, 59, 1'b1, 1'b1);
        else          chk("top_wrap", 0, 0, 1'b1, 1'b0);

        // Pause keeps the partial second: tick 2 cycles after re-enable.
        step(1,0,1,0,0);
        step(0,1,1,0,0);
        step(0,1,1,0,0);
        for (int i = 0; i < 10; i++) step(0,0,1,0,0);
        chk("pause_hold", 0, 0, 1'b0, 1'b0);
        step(0,1,1,0,0);
        chk("resume_1", 0, 0, 1'b0, 1'b0);
        step(0,1,1,0,0);
        chk("resume_2", 0, 1, 1'b1, 1'b0);

        // Reset coincident with a down tick at 00:01 wins.
        step(1,0,0,0,0);
        step(0,0,0,1,0);
        for (int i = 0; i < 3; i++) step(0,1,0,0,0);
        chk("pre_rst_tick", 0, 1, 1'b0, 1'b0);
        step(1,1,0,0,0);
        chk("rst_on_tick", 0, 0, 1'b0, 1'b0);
        step(0,1,0,0,0);
        chk("rst_presc_clr", 0, 0, 1'b0, 1'b0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 4000; i++) begin
            step(logic'($urandom_range(0, 299) == 0),
                 logic'($urandom_range(0, 3) != 0),
                 logic'($urandom_range(0, 1)),
                 logic'($urandom_range(0, 3) == 0),
                 logic'($urandom_range(0, 5) == 0));
            chk("random", m_t / 60, m_t % 60, m_tick, m_fin);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
